mux_scan_nx1: RTL and testbench
===============================

# mux_scan_nx1

Parametrised N-channel to 1 multiplexer with a registered output and a valid/ready handshake. It replaces the fixed 32:1 single-bit mux in the datapath. Selection runs in one of two modes: direct, driven by an external select, or scan, which steps round-robin over the enabled channels. It sits between a bank of sampled sources and a single-lane consumer, such as a serialiser or logger.

## Interface
- WIDTH, 1, bits per channel
- N_CH, 32, number of channels; multiple of GRP, ≥ 2
- GRP, 8, leaf mux size; power of two
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- ch_data  in  N_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- ch_en  in  N_CH  per-channel enable mask
- mode  in  1  0 = direct, 1 = scan
- sel  in  $clog2(N_CH)  channel select, direct mode only
- out_data  out  WIDTH  registered sample
- out_ch  out  $clog2(N_CH)  channel index of out_data
- out_valid  out  1  out_data/out_ch hold a sample
- out_ready  in  1  consumer accepts the sample
- sel_err  out  1  one-cycle pulse when a direct-mode load is refused

## Operation
- Load opportunity (LO) is `!out_valid || (out_valid && out_ready)`.
- Candidate channel c:
  - Direct mode: c = sel. The candidate is legal iff sel < N_CH and ch_en[sel].
  - Scan mode: c = first channel with ch_en set, searching from ptr upward and wrapping from N_CH-1 to 0. There is no candidate if ch_en is all zero.
- On an LO with a legal candidate:
  - out_data ← ch_data[c], out_ch ← c, out_valid ← 1.
  - Scan mode only: ptr ← (c+1) mod N_CH.
- On an LO with no legal candidate:
  - out_valid ← 0. out_data and out_ch hold their last values.
  - If in direct mode, sel_err = 1 for that cycle.
- No LO (out_valid && !out_ready): all output registers hold, ptr holds, sel_err = 0.
- ptr persists across mode changes. It is updated only by scan-mode loads.
- mode, sel and ch_en are sampled only at an LO edge. A change takes effect at the next LO, never retroactively.
- Scan fairness: with k enabled channels and out_ready held high, each enabled channel is emitted exactly once per k consecutive loads, in ascending order with wrap.
- Disabling the channel currently on the output does not retract it. The sample stays valid until accepted.
- Reset, including mid-transfer: out_valid=0, out_data=0, out_ch=0, ptr=0, sel_err=0. Any pending sample is discarded.

## Timing
- Latency: ch_data sampled at LO edge t appears on out_data after edge t, i.e. one cycle.
- Throughput: one sample per cycle while out_ready=1 and a legal candidate exists.
- out_valid is never deasserted while out_ready=0; data must be stable while valid and not ready.
- out_ready may be asserted combinationally by the consumer. No combinational path from out_ready to out_data or out_ch.
- sel_err is registered and asserted in the cycle after the refused LO edge.
- First valid sample after reset: edge 1 after rst deasserts, given a legal candidate at that edge.

## Structure
- Package mux_pkg holds:
  - MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
  - Function next_en(mask, ptr), which returns {found, idx} for the wrapped priority search.
- Sub-module mux_grp: a GRP:1 WIDTH-bit leaf mux with an en input; output is 0 when en=0.
  - The top instantiates N_CH/GRP of them.
  - Group select is the low $clog2(GRP) bits of c; the upper bits one-hot enable a group.
  - Group outputs are OR-reduced into the output register.
- The top holds the ptr register, the candidate logic, the handshake and the output registers.

## Test plan
- Reset then direct mode, WIDTH=4, ch_en=all 1, ch_data[c]=c mod 16, sel=19, out_ready=1 → edge 1: out_valid=1, out_ch=19, out_data=3; one new sample per cycle thereafter.
- Direct mode, sel=5 with ch_en[5]=0 → out_valid=0 and a one-cycle sel_err pulse; set ch_en[5]=1 → valid at the next edge.
- Scan mode, ch_en bits {2, 9, 31} set, out_ready=1 → out_ch sequence 2, 9, 31, 2, 9, … with no gaps.
- Scan mode, out_ready=0 for 5 cycles mid-stream → out_data/out_ch frozen, ptr frozen; release → sequence resumes with the next enabled channel, none skipped or repeated.
- Scan mode, ch_en=0 → out_valid drops after the pending sample is accepted; no sel_err; re-enable channel 7 → out_ch=7.
- rst asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_data=0, out_ch=0; first scan after release starts at channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg
// Shared definitions for the scanning N:1 multiplexer.
//   mode_e   : selection mode encoding (direct select or round-robin scan)
//   MAX_CH   : largest channel count the scan search supports
//   IDX_W    : width of a channel index inside the search helper
//   next_en  : wrapped priority search over an enable mask
package mux_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int MAX_CH = 256;
    localparam int IDX_W  = 8;

    // Finds the first set bit of mask, starting at ptr and walking upward
    // with wrap. The mask is zero-padded to MAX_CH bits by the caller, so
    // wrapping at MAX_CH gives the same answer as wrapping at N_CH: the
    // padding bits are never set and are simply skipped.
    // Returns {found, idx}; idx is 0 when nothing is found.
    function automatic logic [IDX_W:0] next_en(input logic [MAX_CH-1:0] mask,
                                               input logic [IDX_W-1:0]  ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pos;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            pos = ptr + IDX_W'(i);
            if (!found && mask[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/mux_grp.sv
// mux_grp
// GRP:1 leaf multiplexer of WIDTH-bit lanes, gated by an enable.
//   i_data : GRP lanes, lane k at [k*WIDTH +: WIDTH]
//   i_sel  : lane select within the group
//   i_en   : group enable; output forced to zero when low
//   o_data : selected lane, or zero
module mux_grp
    import mux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int GRP   = 8
) (
    input  logic [GRP*WIDTH-1:0]    i_data,
    input  logic [$clog2(GRP)-1:0]  i_sel,
    input  logic                    i_en,
    output logic [WIDTH-1:0]        o_data
);

    // A disabled group contributes zero so the top can OR all groups together.
    always_comb begin
        o_data = '0;
        if (i_en) begin
            o_data = i_data[i_sel*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1
// N_CH:1 multiplexer with a registered output and valid/ready handshake.
// Direct mode takes the channel from i_sel; scan mode steps round-robin
// over the enabled channels starting from an internal pointer.
//   i_clk       : rising-edge clock
//   i_rst       : synchronous active-high reset
//   i_ch_data   : channel c at [c*WIDTH +: WIDTH]
//   i_ch_en     : per-channel enable mask
//   i_mode      : 0 = direct, 1 = scan
//   i_sel       : channel select (direct mode)
//   i_out_ready : consumer accepts the current sample
//   o_out_data  : registered sample
//   o_out_ch    : channel index of o_out_data
//   o_out_valid : o_out_data/o_out_ch hold a sample
//   o_sel_err   : one-cycle pulse after a refused direct-mode load
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int N_CH  = 32,
    parameter int GRP   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_CH*WIDTH-1:0]    i_ch_data,
    input  logic [N_CH-1:0]          i_ch_en,
    input  logic                     i_mode,
    input  logic [$clog2(N_CH)-1:0]  i_sel,
    output logic [WIDTH-1:0]         o_out_data,
    output logic [$clog2(N_CH)-1:0]  o_out_ch,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic                     o_sel_err
);

    localparam int SEL_W = $clog2(N_CH);
    localparam int GRP_W = $clog2(GRP);
    localparam int N_GRP = N_CH / GRP;

    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_ch;
    logic             r_valid;
    logic             r_sel_err;
    logic [SEL_W-1:0] r_ptr;

    logic [MAX_CH-1:0] w_mask_pad;
    logic [IDX_W:0]    w_scan;
    logic [SEL_W-1:0]  w_cand;
    logic              w_legal;
    logic              w_lo;
    logic [SEL_W-1:0]  w_next_ptr;
    logic [N_GRP-1:0]  w_grp_en;
    logic [WIDTH-1:0]  w_grp_out [N_GRP];
    logic [WIDTH-1:0]  w_mux_data;

    assign w_mask_pad = MAX_CH'(i_ch_en);
    assign w_scan     = next_en(w_mask_pad, IDX_W'(r_ptr));

    // A new sample may be loaded whenever the output is empty or being taken.
    // out_ready only steers register enables, never the data path.
    assign w_lo = !r_valid || i_out_ready;

    // Candidate channel and its legality for the current mode. The range
    // test on the scan index can only fail if the mask were wider than
    // N_CH; it keeps the search result fully qualified.
    always_comb begin
        w_cand  = '0;
        w_legal = 1'b0;
        if (i_mode == MODE_SCAN) begin
            w_cand  = SEL_W'(w_scan[IDX_W-1:0]);
            w_legal = w_scan[IDX_W] && (int'(w_scan[IDX_W-1:0]) < N_CH);
        end else begin
            w_cand  = i_sel;
            w_legal = (int'(i_sel) < N_CH) && i_ch_en[i_sel];
        end
    end

    assign w_next_ptr = (int'(w_cand) == N_CH - 1) ? '0 : w_cand + SEL_W'(1);

    // Two-level mux: the upper bits of the candidate pick one group, the
    // low bits pick a lane within it, and the gated group outputs are ORed.
    for (genvar g = 0; g < N_GRP; g++) begin : g_grp
        assign w_grp_en[g] = ((int'(w_cand) >> GRP_W) == g);

        mux_grp #(
            .WIDTH (WIDTH),
            .GRP   (GRP)
        ) u_grp (
            .i_data (i_ch_data[g*GRP*WIDTH +: GRP*WIDTH]),
            .i_sel  (w_cand[GRP_W-1:0]),
            .i_en   (w_grp_en[g]),
            .o_data (w_grp_out[g])
        );
    end

    always_comb begin
        w_mux_data = '0;
        for (int g = 0; g < N_GRP; g++) begin
            w_mux_data = w_mux_data | w_grp_out[g];
        end
    end

    // Output registers and scan pointer. A refused load clears valid but
    // leaves data/channel untouched; only scan-mode loads move the pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data    <= '0;
            r_ch      <= '0;
            r_valid   <= 1'b0;
            r_sel_err <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_sel_err <= 1'b0;
            if (w_lo) begin
                if (w_legal) begin
                    r_data  <= w_mux_data;
                    r_ch    <= w_cand;
                    r_valid <= 1'b1;
                    if (i_mode == MODE_SCAN) begin
                        r_ptr <= w_next_ptr;
                    end
                end else begin
                    r_valid   <= 1'b0;
                    r_sel_err <= (i_mode == MODE_DIRECT);
                end
            end
        end
    end

    assign o_out_data  = r_data;
    assign o_out_ch    = r_ch;
    assign o_out_valid = r_valid;
    assign o_sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1
// Directed bench for mux_scan_nx1 with WIDTH=4, N_CH=32, GRP=8.
// Channel c carries the value c mod 16. Inputs change 1 time unit after a
// rising edge; outputs are checked at that same point.
module tb_mux_scan_nx1;

    localparam int WIDTH = 4;
    localparam int N_CH  = 32;
    localparam int GRP   = 8;

    logic                    clk;
    logic                    rst;
    logic [N_CH*WIDTH-1:0]   chData;
    logic [N_CH-1:0]         chEn;
    logic                    mode;
    logic [4:0]              sel;
    logic [WIDTH-1:0]        outData;
    logic [4:0]              outCh;
    logic                    outValid;
    logic                    outReady;
    logic                    selErr;

    int total = 0;
    int bad   = 0;

    mux_scan_nx1 #(
        .WIDTH (WIDTH),
        .N_CH  (N_CH),
        .GRP   (GRP)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ch_data   (chData),
        .i_ch_en     (chEn),
        .i_mode      (mode),
        .i_sel       (sel),
        .o_out_data  (outData),
        .o_out_ch    (outCh),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_sel_err   (selErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all control inputs at once
    task automatic applyStimulus(input logic r, input logic m, input logic [4:0] s,
                                 input logic [N_CH-1:0] en, input logic rdy);
        rst      = r;
        mode     = m;
        sel      = s;
        chEn     = en;
        outReady = rdy;
    endtask

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks the full output state in one call
    task automatic checkAll(input string tag, input logic v, input logic [4:0] ch,
                            input logic [3:0] d, input logic e);
        checkOutput({tag, ".valid"}, 32'(outValid), 32'(v));
        checkOutput({tag, ".ch"},    32'(outCh),    32'(ch));
        checkOutput({tag, ".data"},  32'(outData),  32'(d));
        checkOutput({tag, ".selerr"},32'(selErr),   32'(e));
    endtask

    localparam logic [N_CH-1:0] ALL_ON  = '1;
    localparam logic [N_CH-1:0] SCAN_EN = (32'd1 << 2) | (32'd1 << 9) | (32'd1 << 31);

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            chData[c*WIDTH +: WIDTH] = 4'(c % 16);
        end
        $display("[TB] starting");

        // Reset with a legal direct candidate present
        applyStimulus(1'b1, 1'b0, 5'd19, ALL_ON, 1'b1);
        step();
        step();
        checkAll("reset", 1'b0, 5'd0, 4'd0, 1'b0);

        // Direct mode: first sample on edge 1 after reset release
        applyStimulus(1'b0, 1'b0, 5'd19, ALL_ON, 1'b1);
        step();
        checkAll("direct19", 1'b1, 5'd19, 4'd3, 1'b0);
        sel = 5'd20;
        step();
        checkAll("direct20", 1'b1, 5'd20, 4'd4, 1'b0);
        sel = 5'd31;
        step();
        checkAll("direct31", 1'b1, 5'd31, 4'd15, 1'b0);

        // Direct select of a disabled channel is refused
        applyStimulus(1'b0, 1'b0, 5'd5, ALL_ON & ~(32'd1 << 5), 1'b1);
        step();
        checkAll("refuse5", 1'b0, 5'd31, 4'd15, 1'b1);
        chEn = ALL_ON;
        step();
        checkAll("accept5", 1'b1, 5'd5, 4'd5, 1'b0);

        // Direct mode backpressure: select change ignored until accepted
        applyStimulus(1'b0, 1'b0, 5'd6, ALL_ON, 1'b0);
        step();
        checkAll("direct_hold", 1'b1, 5'd5, 4'd5, 1'b0);

        // Scan over channels 2, 9, 31 with wrap; pointer still 0
        applyStimulus(1'b0, 1'b1, 5'd0, SCAN_EN, 1'b1);
        step();
        checkAll("scan_a2", 1'b1, 5'd2, 4'd2, 1'b0);
        step();
        checkAll("scan_a9", 1'b1, 5'd9, 4'd9, 1'b0);
        step();
        checkAll("scan_a31", 1'b1, 5'd31, 4'd15, 1'b0);
        step();
        checkAll("scan_b2", 1'b1, 5'd2, 4'd2, 1'b0);
        step();
        checkAll("scan_b9", 1'b1, 5'd9, 4'd9, 1'b0);

        // Stall five cycles: output frozen on channel 9
        outReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checkAll("stall9", 1'b1, 5'd9, 4'd9, 1'b0);
        end
        outReady = 1'b1;
        step();
        checkAll("resume31", 1'b1, 5'd31, 4'd15, 1'b0);
        step();
        checkAll("resume2", 1'b1, 5'd2, 4'd2, 1'b0);

        // Mask cleared while stalled: pending sample stays valid
        applyStimulus(1'b0, 1'b1, 5'd0, '0, 1'b0);
        step();
        checkAll("empty_hold", 1'b1, 5'd2, 4'd2, 1'b0);
        outReady = 1'b1;
        step();
        checkAll("empty_drop", 1'b0, 5'd2, 4'd2, 1'b0);
        step();
        checkAll("empty_idle", 1'b0, 5'd2, 4'd2, 1'b0);
        chEn = 32'd1 << 7;
        step();
        checkAll("reenable7", 1'b1, 5'd7, 4'd7, 1'b0);

        // Reset during a stalled transfer, then scan restarts from channel 0
        applyStimulus(1'b0, 1'b1, 5'd0, ALL_ON, 1'b0);
        rst = 1'b1;
        step();
        checkAll("midreset", 1'b0, 5'd0, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd0, ALL_ON, 1'b1);
        step();
        checkAll("post_rst0", 1'b1, 5'd0, 4'd0, 1'b0);
        step();
        checkAll("post_rst1", 1'b1, 5'd1, 4'd1, 1'b0);
        step();
        checkAll("post_rst2", 1'b1, 5'd2, 4'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
